// File: rtl/csr_ctrl_pkg.sv
// Shared encodings for the CSR access controller: funct3 ops, trap CSR
// addresses and FSM state codes.
package csr_ctrl_pkg;

    localparam logic [2:0] OP_RW  = 3'b001;
    localparam logic [2:0] OP_RS  = 3'b010;
    localparam logic [2:0] OP_RC  = 3'b011;
    localparam logic [2:0] OP_RWI = 3'b101;
    localparam logic [2:0] OP_RSI = 3'b110;
    localparam logic [2:0] OP_RCI = 3'b111;

    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVEC  = 12'h305;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_P_RD    = 3'd1;
    localparam state_t S_P_WR    = 3'd2;
    localparam state_t S_T_EPC   = 3'd3;
    localparam state_t S_T_CAUSE = 3'd4;
    localparam state_t S_T_VEC   = 3'd5;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op != 3'b000) && (op != 3'b100);
    endfunction

endpackage

// File: rtl/csr_access_ctrl_alu.sv
// Combinational write-data and write-enable for the CSR read-modify-write
// ops. Illegal ops never write.
module csr_alu
    import csr_ctrl_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_old,
    input  logic [31:0] i_rs1,
    input  logic [4:0]  i_zimm,
    input  logic        i_src_zero,
    input  logic        i_idx_valid,
    output logic [31:0] o_wdata,
    output logic        o_we
);

    logic [31:0] w_src;

    assign w_src = i_op[2] ? {27'b0, i_zimm} : i_rs1;

    always_comb begin
        o_wdata = '0;
        o_we    = 1'b0;
        case (i_op)
            OP_RW, OP_RWI: begin
                o_wdata = w_src;
                o_we    = i_idx_valid;
            end
            // set/clear with a zero source is a pure read
            OP_RS, OP_RSI: begin
                o_wdata = i_old | w_src;
                o_we    = i_idx_valid & ~i_src_zero;
            end
            OP_RC, OP_RCI: begin
                o_wdata = i_old & ~w_src;
                o_we    = i_idx_valid & ~i_src_zero;
            end
            default: begin
                o_wdata = '0;
                o_we    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// Arbitrates the pipeline CSR port and the trap unit onto the CSR file's
// single read and write port. Trap wins ties; pipeline ops are never preempted.
//
// state     | meaning
// IDLE      | wait for a request, latch its fields
// P_RD      | read old CSR value into old_q
// P_WR      | write modified value, pulse pipe_done
// T_EPC     | write mepc
// T_CAUSE   | write mcause
// T_VEC     | read mtvec, pulse trap_done
module csr_access_ctrl
    import csr_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pipe_req,
    input  logic [2:0]  i_pipe_op,
    input  logic [11:0] i_pipe_addr,
    input  logic [31:0] i_pipe_rs1_data,
    input  logic [4:0]  i_pipe_zimm,
    input  logic        i_pipe_src_zero,
    output logic        o_pipe_done,
    output logic [31:0] o_pipe_rdata,
    input  logic        i_trap_req,
    input  logic [31:0] i_trap_epc,
    input  logic [31:0] i_trap_cause,
    output logic        o_trap_done,
    output logic [31:0] o_trap_vector,
    output logic        o_csr_read_en,
    output logic [11:0] o_csr_raddr,
    input  logic [31:0] i_csr_rdata,
    output logic        o_csr_write_en,
    output logic [11:0] o_csr_waddr,
    output logic [31:0] o_csr_wdata
);

    state_t      r_state;
    logic [2:0]  r_op;
    logic [11:0] r_addr;
    logic [31:0] r_rs1;
    logic [4:0]  r_zimm;
    logic        r_src_zero;
    logic [31:0] r_epc;
    logic [31:0] r_cause;
    logic [31:0] r_old;

    logic        w_idx_valid;
    logic [31:0] w_alu_wdata;
    logic        w_alu_we;

    // index 0 has no backing register in the file
    assign w_idx_valid = (r_addr[4:0] != 5'd0);

    csr_alu u_alu (
        .i_op        (r_op),
        .i_old       (r_old),
        .i_rs1       (r_rs1),
        .i_zimm      (r_zimm),
        .i_src_zero  (r_src_zero),
        .i_idx_valid (w_idx_valid),
        .o_wdata     (w_alu_wdata),
        .o_we        (w_alu_we)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_addr     <= '0;
            r_rs1      <= '0;
            r_zimm     <= '0;
            r_src_zero <= 1'b0;
            r_epc      <= '0;
            r_cause    <= '0;
            r_old      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_trap_req) begin
                        r_epc   <= i_trap_epc;
                        r_cause <= i_trap_cause;
                        r_state <= S_T_EPC;
                    end else if (i_pipe_req) begin
                        r_op       <= i_pipe_op;
                        r_addr     <= i_pipe_addr;
                        r_rs1      <= i_pipe_rs1_data;
                        r_zimm     <= i_pipe_zimm;
                        r_src_zero <= i_pipe_src_zero;
                        r_old      <= '0;
                        r_state    <= is_legal_op(i_pipe_op) ? S_P_RD : S_P_WR;
                    end
                end
                S_P_RD: begin
                    r_old   <= w_idx_valid ? i_csr_rdata : '0;
                    r_state <= S_P_WR;
                end
                S_P_WR:    r_state <= S_IDLE;
                S_T_EPC:   r_state <= S_T_CAUSE;
                S_T_CAUSE: r_state <= S_T_VEC;
                S_T_VEC:   r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_pipe_done    = 1'b0;
        o_pipe_rdata   = '0;
        o_trap_done    = 1'b0;
        o_trap_vector  = '0;
        o_csr_read_en  = 1'b0;
        o_csr_raddr    = '0;
        o_csr_write_en = 1'b0;
        o_csr_waddr    = '0;
        o_csr_wdata    = '0;
        case (r_state)
            S_P_RD: begin
                o_csr_read_en = w_idx_valid;
                o_csr_raddr   = r_addr;
            end
            S_P_WR: begin
                o_pipe_done    = 1'b1;
                o_pipe_rdata   = r_old;
                o_csr_write_en = w_alu_we;
                o_csr_waddr    = r_addr;
                o_csr_wdata    = w_alu_wdata;
            end
            S_T_EPC: begin
                o_csr_write_en = 1'b1;
                o_csr_waddr    = CSR_MEPC;
                o_csr_wdata    = r_epc;
            end
            S_T_CAUSE: begin
                o_csr_write_en = 1'b1;
                o_csr_waddr    = CSR_MCAUSE;
                o_csr_wdata    = r_cause;
            end
            // the mepc/mcause writes above land on earlier negedges, so this read is current
            S_T_VEC: begin
                o_csr_read_en = 1'b1;
                o_csr_raddr   = CSR_MTVEC;
                o_trap_done   = 1'b1;
                o_trap_vector = {i_csr_rdata[31:2], 2'b00};
            end
            default: begin
                o_pipe_done = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: a behavioural CSR file plus a
// reference array predict every pipeline and trap transaction.
module tb_csr_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_req = 1'b0;
    logic [2:0]  pipe_op = '0;
    logic [11:0] pipe_addr = '0;
    logic [31:0] pipe_rs1_data = '0;
    logic [4:0]  pipe_zimm = '0;
    logic        pipe_src_zero = 1'b0;
    logic        pipe_done;
    logic [31:0] pipe_rdata;
    logic        trap_req = 1'b0;
    logic [31:0] trap_epc = '0;
    logic [31:0] trap_cause = '0;
    logic        trap_done;
    logic [31:0] trap_vector;
    logic        csr_read_en;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_write_en;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;

    logic [31:0] file_m [32];
    logic [31:0] ref_m  [32];
    logic        bk_clr = 1'b0;

    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [11:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    int          n_chk  = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    csr_access_ctrl dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_pipe_req      (pipe_req),
        .i_pipe_op       (pipe_op),
        .i_pipe_addr     (pipe_addr),
        .i_pipe_rs1_data (pipe_rs1_data),
        .i_pipe_zimm     (pipe_zimm),
        .i_pipe_src_zero (pipe_src_zero),
        .o_pipe_done     (pipe_done),
        .o_pipe_rdata    (pipe_rdata),
        .i_trap_req      (trap_req),
        .i_trap_epc      (trap_epc),
        .i_trap_cause    (trap_cause),
        .o_trap_done     (trap_done),
        .o_trap_vector   (trap_vector),
        .o_csr_read_en   (csr_read_en),
        .o_csr_raddr     (csr_raddr),
        .i_csr_rdata     (csr_rdata),
        .o_csr_write_en  (csr_write_en),
        .o_csr_waddr     (csr_waddr),
        .o_csr_wdata     (csr_wdata)
    );

    // CSR file: asynchronous read, negedge write
    assign csr_rdata = file_m[csr_raddr[4:0]];

    always @(negedge clk) begin
        if (bk_clr) begin
            for (int i = 0; i < 32; i++) file_m[i] <= '0;
        end else if (csr_write_en) begin
            file_m[csr_waddr[4:0]] <= csr_wdata;
        end
    end

    always @(negedge clk) begin
        if (csr_write_en) begin
            wr_cnt     = wr_cnt + 1;
            last_waddr = csr_waddr;
            last_wdata = csr_wdata;
        end
        if (csr_read_en) rd_cnt = rd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // drive: present the request here; otherwise the caller already holds it.
    // extra: cycles the request waits before IDLE accepts it.
    task automatic pipe_txn(input logic [2:0] op, input logic [11:0] addr,
                            input logic [31:0] rs1, input logic [4:0] zimm,
                            input logic sz, input bit drive, input int extra,
                            input bit raise_trap);
        logic [4:0]  idx;
        logic        legal, wr;
        logic [31:0] src, old, nv, got;
        int          exp_cyc, cyc, wb, rb;
        idx   = addr[4:0];
        legal = !(op == 3'b000 || op == 3'b100);
        src   = op[2] ? {27'b0, zimm} : rs1;
        old   = (legal && idx != 0) ? ref_m[idx] : 32'h0;
        case (op)
            3'b001, 3'b101: begin nv = src;        wr = 1'b1; end
            3'b010, 3'b110: begin nv = old | src;  wr = !sz;  end
            3'b011, 3'b111: begin nv = old & ~src; wr = !sz;  end
            default:        begin nv = 32'h0;      wr = 1'b0; end
        endcase
        if (idx == 0) wr = 1'b0;
        exp_cyc = (legal ? 2 : 1) + extra;
        wb = wr_cnt;
        rb = rd_cnt;
        if (drive) begin
            @(negedge clk);
            pipe_req = 1'b1; pipe_op = op; pipe_addr = addr;
            pipe_rs1_data = rs1; pipe_zimm = zimm; pipe_src_zero = sz;
        end
        cyc = 0;
        got = 32'hDEAD_BEEF;
        for (int c = 1; c <= exp_cyc + 4; c++) begin
            @(posedge clk); #1;
            if (c == 1 && drive) begin
                pipe_op = 3'($urandom); pipe_addr = 12'($urandom);
                pipe_rs1_data = $urandom; pipe_zimm = 5'($urandom);
                pipe_src_zero = 1'($urandom);
                if (raise_trap) trap_req = 1'b1;
            end
            if (pipe_done) begin
                cyc = c;
                got = pipe_rdata;
                break;
            end
        end
        @(negedge clk);
        pipe_req = 1'b0;
        #1;
        chk("pipe_latency", cyc, exp_cyc);
        chk("pipe_rdata", got, old);
        chk("pipe_writes", wr_cnt - wb, wr ? 1 : 0);
        chk("pipe_reads", rd_cnt - rb, (legal && idx != 0) ? 1 : 0);
        if (wr) begin
            chk("pipe_wdata", last_wdata, nv);
            chk("pipe_waddr", {20'b0, last_waddr}, {20'b0, addr});
            ref_m[idx] = nv;
        end
    endtask

    task automatic trap_txn(input logic [31:0] epc, input logic [31:0] cause,
                            input bit drive, input int exp_cyc);
        int          cyc, wb, rb;
        logic [31:0] vec, exp_vec;
        wb = wr_cnt;
        rb = rd_cnt;
        if (drive) begin
            @(negedge clk);
            trap_epc = epc; trap_cause = cause; trap_req = 1'b1;
        end
        exp_vec = ref_m[5] & 32'hFFFF_FFFC;
        cyc = 0;
        vec = 32'hDEAD_BEEF;
        for (int c = 1; c <= exp_cyc + 4; c++) begin
            @(posedge clk); #1;
            if (trap_done) begin
                cyc = c;
                vec = trap_vector;
                break;
            end
        end
        @(negedge clk);
        trap_req = 1'b0;
        #1;
        chk("trap_latency", cyc, exp_cyc);
        chk("trap_vector", vec, exp_vec);
        chk("trap_writes", wr_cnt - wb, 2);
        chk("trap_reads", rd_cnt - rb, 1);
        chk("trap_mepc", file_m[1], epc);
        chk("trap_mcause", file_m[2], cause);
        ref_m[1] = epc;
        ref_m[2] = cause;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_pipe_done"}, {31'b0, pipe_done}, 32'h0);
        chk({tag, "_pipe_rdata"}, pipe_rdata, 32'h0);
        chk({tag, "_trap_done"}, {31'b0, trap_done}, 32'h0);
        chk({tag, "_trap_vector"}, trap_vector, 32'h0);
        chk({tag, "_read_en"}, {31'b0, csr_read_en}, 32'h0);
        chk({tag, "_raddr"}, {20'b0, csr_raddr}, 32'h0);
        chk({tag, "_write_en"}, {31'b0, csr_write_en}, 32'h0);
        chk({tag, "_waddr"}, {20'b0, csr_waddr}, 32'h0);
        chk({tag, "_wdata"}, csr_wdata, 32'h0);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [11:0] r_addr;
        logic [31:0] r_rs1;
        logic [4:0]  r_zimm;
        logic        r_sz;

        for (int i = 0; i < 32; i++) ref_m[i] = '0;
        bk_clr = 1'b1;
        repeat (2) @(negedge clk);
        bk_clr = 1'b0;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // mstatus = 8, then CSRRS sets bit 7, then read back
        pipe_txn(3'b001, 12'h300, 32'h8, 5'd0, 1'b0, 1, 0, 0);
        pipe_txn(3'b010, 12'h300, 32'h80, 5'd0, 1'b0, 1, 0, 0);
        pipe_txn(3'b010, 12'h300, 32'h0, 5'd0, 1'b1, 1, 0, 0);
        // CSRRCI with zimm=0 never writes
        pipe_txn(3'b111, 12'h300, 32'h0, 5'd0, 1'b1, 1, 0, 0);
        // mtvec with low bits set
        pipe_txn(3'b001, 12'h305, 32'h8000_0001, 5'd0, 1'b0, 1, 0, 0);

        // simultaneous requests: trap first, then pipeline op
        @(negedge clk);
        pipe_req = 1'b1; pipe_op = 3'b001; pipe_addr = 12'h300;
        pipe_rs1_data = 32'h1234; pipe_zimm = 5'd0; pipe_src_zero = 1'b0;
        trap_epc = 32'h100; trap_cause = 32'hB; trap_req = 1'b1;
        trap_txn(32'h100, 32'hB, 0, 3);
        pipe_txn(3'b001, 12'h300, 32'h1234, 5'd0, 1'b0, 0, 1, 0);

        // trap raised while a CSRRW is in P_RD
        trap_epc = 32'h100; trap_cause = 32'hB;
        pipe_txn(3'b001, 12'h301, 32'hABCD, 5'd0, 1'b0, 1, 0, 1);
        trap_txn(32'h100, 32'hB, 0, 4);
        pipe_txn(3'b010, 12'h341, 32'h0, 5'd0, 1'b1, 1, 0, 0);
        pipe_txn(3'b010, 12'h342, 32'h0, 5'd0, 1'b1, 1, 0, 0);

        // illegal ops and the unbacked index 0
        pipe_txn(3'b100, 12'h300, 32'hFFFF, 5'd3, 1'b0, 1, 0, 0);
        pipe_txn(3'b000, 12'h305, 32'hFFFF, 5'd3, 1'b0, 1, 0, 0);
        pipe_txn(3'b001, 12'h340, 32'h5, 5'd0, 1'b0, 1, 0, 0);

        // reset while in T_CAUSE: mepc already written, mcause not
        @(negedge clk);
        trap_epc = 32'h200; trap_cause = 32'h7; trap_req = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_outputs_zero("rst_tcause");
        trap_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mepc_kept", file_m[1], 32'h200);
        chk("rst_mcause_unwritten", file_m[2], ref_m[2]);
        ref_m[1] = 32'h200;
        pipe_txn(3'b010, 12'h342, 32'h0, 5'd0, 1'b1, 1, 0, 0);
        pipe_txn(3'b010, 12'h341, 32'h0, 5'd0, 1'b1, 1, 0, 0);

        // randomized mix of pipeline ops with occasional traps
        for (int n = 0; n < 60; n++) begin
            r_op   = 3'($urandom);
            r_addr = 12'($urandom);
            if ($urandom_range(0, 7) == 0) r_addr[4:0] = 5'd0;
            r_rs1  = $urandom;
            r_zimm = 5'($urandom);
            if (r_op[2]) begin
                r_sz = (r_zimm == 5'd0);
            end else begin
                r_sz = ($urandom_range(0, 5) == 0);
                if (r_sz) r_rs1 = 32'h0;
            end
            pipe_txn(r_op, r_addr, r_rs1, r_zimm, r_sz, 1, 0, 0);
            if ($urandom_range(0, 9) == 0) trap_txn($urandom, $urandom, 1, 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/csr_access_ctrl.md
# csr_access_ctrl

Sequencer and arbiter in front of the CSR register file (negedge write, asynchronous read, index = addr[4:0]). Serves two requesters, the pipeline CSR instruction port (CSRRW/S/C and immediate forms, atomic read-modify-write) and the trap unit (mepc/mcause write, then mtvec fetch), and drives the file's single read and single write port. Sits between the EX-stage CSR logic, the exception unit and the CSR file.

## Interface
- No parameters. Fixed constants: MEPC=12'h341, MCAUSE=12'h342, MTVEC=12'h305.
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- pipe_req  in  1  CSR instruction request; held until pipe_done
- pipe_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 illegal
- pipe_addr  in  12  CSR address
- pipe_rs1_data  in  32  register operand
- pipe_zimm  in  5  immediate operand (zero-extended)
- pipe_src_zero  in  1  rs1 index or zimm is 0
- pipe_done  out  1  one-cycle completion pulse
- pipe_rdata  out  32  old CSR value, valid while pipe_done
- trap_req  in  1  trap entry request; held until trap_done
- trap_epc  in  32  value for mepc
- trap_cause  in  32  value for mcause
- trap_done  out  1  one-cycle completion pulse
- trap_vector  out  32  {mtvec[31:2],2'b00}, valid while trap_done
- csr_read_en  out  1  to file read enable
- csr_raddr  out  12  to file read address
- csr_rdata  in  32  from file read data
- csr_write_en  out  1  to file write enable
- csr_waddr  out  12  to file write address
- csr_wdata  out  32  to file write data

## Operation
- States: IDLE, P_RD, P_WR, T_EPC, T_CAUSE, T_VEC.
- IDLE: trap_req -> T_EPC (trap wins a tie); else pipe_req -> P_RD; else stay. Request fields latched on leaving IDLE; later input changes are ignored.
- P_RD: csr_read_en=1, csr_raddr=latched addr; csr_rdata captured into old_q at end of cycle. -> P_WR.
- P_WR: pipe_done=1, pipe_rdata=old_q; csr_write_en per write rule, csr_waddr=addr, csr_wdata=f(op, old_q, src). -> IDLE.
- src = pipe_rs1_data for op[2]=0, {27'b0,zimm} for op[2]=1. RW: src; RS: old_q|src; RC: old_q&~src.
- Write suppressed for RS/RC/RSI/RCI when pipe_src_zero=1; RW/RWI always write.
- addr[4:0]==0 (no file entry): read skipped, old_q=0, write suppressed, done still pulses.
- Illegal op: P_RD skipped; IDLE -> P_WR with no read and no write, pipe_rdata=0.
- T_EPC: write MEPC<=trap_epc. T_CAUSE: write MCAUSE<=trap_cause. T_VEC: read MTVEC, trap_done=1, trap_vector=masked csr_rdata.
- A pipeline op in progress is never preempted; a trap raised during P_RD/P_WR is taken in the following IDLE cycle.
- csr_*_en are 0 in every state not listed above.

## Timing
- Pipeline op latency: req sampled in IDLE at edge 0; P_RD in cycle 1; pipe_done in cycle 2. Illegal op: done in cycle 1.
- Trap latency: trap_done in cycle 3 (T_EPC 1, T_CAUSE 2, T_VEC 3).
- Writes land at the negedge of the issuing cycle, so a subsequent access sees the new value; mtvec read in T_VEC sees mepc/mcause updates.
- Requesters drop req on the edge that samples done. IDLE always spends at least one cycle between ops (no back-to-back accept).
- Reset (any state): FSM=IDLE, old_q=0, all outputs 0 immediately. An operation in flight is abandoned. Trap writes already issued (e.g. mepc) are not rolled back.

## Structure
- Package csr_ctrl_pkg: funct3 op encodings, MEPC/MCAUSE/MTVEC constants, state enum.
- Sub-module csr_alu: combinational RW/RS/RC/immediate result plus write-enable qualification.
- FSM, old_q and latched request fields stay in csr_access_ctrl. All outputs are Moore, except trap_vector, which passes csr_rdata through a mask.

## Test plan
- mstatus=0x0000_0008; CSRRS 0x300, rs1=0x80 -> pipe_rdata=0x8 in cycle 2, write 0x88, then readback 0x88.
- CSRRCI 0x300, zimm=0, pipe_src_zero=1 -> pipe_rdata=old value, csr_write_en never asserted.
- pipe_req and trap_req together (epc=0x100, cause=0xB, mtvec=0x8000_0001) -> trap first, trap_vector=0x8000_0000 in cycle 3, pipe op served after.
- trap_req raised during P_RD of a CSRRW -> CSRRW completes unmodified, trap then runs. mepc/mcause readback: 0x100/0xB.
- Illegal op 3'b100 -> done in cycle 1, rdata 0, no read and no write. addr 0x340 (index 0) -> rdata 0, no write.
- rst pulsed in T_CAUSE -> outputs 0 at once, mcause unwritten, FSM idle, next request served normally.
